// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared matrix-multiplier constants and display sequencer state encoding
package mm_pkg;

    localparam int MM_N      = 3;
    localparam int MM_DATA_W = 16;
    localparam int MM_ADDR_W = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_FETCH = ST_FETCH,
        S_SHOW  = ST_SHOW
    } seq_state_t;

endpackage

// File: rtl/dwell_timer.sv
// rtl/dwell_timer.sv - per-element dwell counter, expire asserted while counting at DWELL-1
module dwell_timer #(
    parameter int DWELL = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(DWELL);
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] count;

    // A frozen counter (enable low) never expires, so hold also blocks advance.
    assign expire = enable && (count == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/mm_display_sequencer.sv
// rtl/mm_display_sequencer.sv - walks the result matrix and drives the seven-segment display word
module mm_display_sequencer
    import mm_pkg::*;
#(
    parameter int N      = MM_N,
    parameter int DATA_W = MM_DATA_W,
    parameter int ADDR_W = MM_ADDR_W,
    parameter int DWELL  = 100_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mm_done,
    input  logic              btn_next,
    input  logic              btn_hold,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] disp_value,
    output logic [ADDR_W-1:0] disp_idx,
    output logic              disp_valid,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N * N - 1);

    seq_state_t        state, next_state;
    logic [ADDR_W-1:0] idx, next_idx;
    logic              restart_pend, next_restart_pend;
    logic              latch_data;
    logic              timer_clear;
    logic              timer_enable;
    logic              expire;

    assign timer_enable = (state == S_SHOW) && !btn_hold;

    dwell_timer #(
        .DWELL(DWELL)
    ) u_dwell_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expire (expire)
    );

    always_comb begin
        next_state        = state;
        next_idx          = idx;
        next_restart_pend = restart_pend;
        latch_data        = 1'b0;
        timer_clear       = 1'b0;
        case (state)
            S_IDLE: begin
                if (mm_done) begin
                    next_state        = S_FETCH;
                    next_idx          = '0;
                    next_restart_pend = 1'b0;
                end
            end
            S_FETCH: begin
                if (rd_ack) begin
                    timer_clear = 1'b1;
                    // A restart seen before or with the ack discards this data and re-requests element 0.
                    if (restart_pend || mm_done) begin
                        next_idx          = '0;
                        next_restart_pend = 1'b0;
                    end else begin
                        latch_data = 1'b1;
                        next_state = S_SHOW;
                    end
                end else if (mm_done) begin
                    next_restart_pend = 1'b1;
                end
            end
            S_SHOW: begin
                if (mm_done) begin
                    next_state = S_FETCH;
                    next_idx   = '0;
                end else if (btn_next || expire) begin
                    next_state = S_FETCH;
                    next_idx   = (idx == LAST_IDX) ? '0 : idx + ADDR_W'(1);
                end
            end
            default: begin
                next_state        = S_IDLE;
                next_idx          = '0;
                next_restart_pend = 1'b0;
            end
        endcase
    end

    // Request outputs are registered from next-state values so no input reaches an output combinationally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            idx          <= '0;
            restart_pend <= 1'b0;
            rd_req       <= 1'b0;
            rd_addr      <= '0;
            busy         <= 1'b0;
            disp_value   <= '0;
            disp_idx     <= '0;
            disp_valid   <= 1'b0;
        end else begin
            state        <= next_state;
            idx          <= next_idx;
            restart_pend <= next_restart_pend;
            rd_req       <= (next_state == S_FETCH);
            rd_addr      <= next_idx;
            busy         <= (next_state != S_IDLE);
            if (latch_data) begin
                disp_value <= rd_data;
                disp_idx   <= idx;
                disp_valid <= 1'b1;
            end
        end
    end

endmodule

// File: doc/mm_display_sequencer.md
# mm_display_sequencer

Scheduler for the 4-digit seven-segment display in the matrix multiplier. After the multiplier signals completion, the block walks the N×N result matrix element by element. For each element it:

- fetches the element from the result memory over a req/ack handshake;
- presents the value as a 16-bit `disp_value` word, which feeds the hex digit generator's switch input;
- holds it for a programmable dwell period before advancing.

User buttons can hold the current element or skip ahead.

## Interface

Parameters:

- `N` — default 3 — matrix dimension; sequence length is N*N.
- `DATA_W` — default 16 — result element width, equal to the display word width.
- `ADDR_W` — default 4 — result memory address width; must satisfy 2^ADDR_W ≥ N*N.
- `DWELL` — default 100_000_000 — cycles each element stays displayed (1 s at 100 MHz); ≥ 2.

Ports:

- `clk` — in — 1 — system clock.
- `rst_n` — in — 1 — synchronous, active-low reset.
- `mm_done` — in — 1 — single-cycle pulse: the result matrix is complete and valid.
- `btn_next` — in — 1 — single-cycle pulse (already debounced): advance to the next element now.
- `btn_hold` — in — 1 — level: while high, the dwell counter freezes.
- `rd_req` — out — 1 — read request to the result memory.
- `rd_addr` — out — ADDR_W — element index, row-major (r*N+c).
- `rd_ack` — in — 1 — memory accepts the request; `rd_data` is valid in the same cycle.
- `rd_data` — in — DATA_W — element data.
- `disp_value` — out — DATA_W — value shown on the display.
- `disp_idx` — out — ADDR_W — index of the element currently shown.
- `disp_valid` — out — 1 — high once any element has been displayed; the display is blanked while low.
- `busy` — out — 1 — high in any state other than IDLE.

## Operation

- **States:** IDLE, FETCH, SHOW.
- **Reset values:** all outputs 0 and the state is IDLE.
- **IDLE:**
  - `mm_done` moves the block to FETCH with `idx`=0.
  - `btn_next` and `btn_hold` are ignored.
- **FETCH:**
  - `rd_req`=1 and `rd_addr`=`idx`; both are held stable until `rd_ack`.
  - On `rd_ack`:
    - `rd_data` is latched into `disp_value`;
    - `disp_idx` is set to `idx`;
    - `disp_valid` is set to 1;
    - the dwell counter is cleared;
    - the block moves to SHOW.
  - `btn_next` is ignored in this state.
- **SHOW:**
  - The dwell counter increments each cycle unless `btn_hold`=1.
  - The block advances when the counter reaches DWELL-1, or on `btn_next` (which applies even while held).
  - Advance means: `idx` becomes `idx`+1, wrapping from N*N-1 to 0, and the block moves to FETCH.
  - `btn_next` and dwell expiry in the same cycle produce a single advance.
- **Restart (`mm_done` outside IDLE):**
  - In SHOW: go to FETCH with `idx`=0 on the next cycle.
  - In FETCH: set a pending-restart flag; the request is not abandoned.
  - On the subsequent `rd_ack` with the flag set:
    - the returned data is discarded, leaving `disp_value`/`disp_idx` unchanged;
    - the flag is cleared;
    - `idx`=0 and the block stays in FETCH, issuing a new request for address 0.
- **Value retention:** `disp_value` keeps the previous element during FETCH, so the display never shows a stale partial value or blanks between elements.
- **Sequence length:** the sequence loops indefinitely until reset; there is no terminal state.
- **Widths:** the dwell counter is $clog2(DWELL) bits. `idx` compares against the constant N*N-1 and never exceeds it.

## Timing

- `mm_done` in cycle t (IDLE): `rd_req`=1 and `rd_addr`=0 from cycle t+1.
- `rd_ack` in cycle t: `rd_req`=0 and the new `disp_value`/`disp_idx`/`disp_valid` are all visible from cycle t+1.
  - An ack in the same cycle `rd_req` first rises is legal.
- Element displayed for DWELL cycles of SHOW, plus FETCH time, absent hold or next.
- `btn_next` in SHOW cycle t: FETCH (`rd_req`=1) from t+1.
- Reset asserted mid-FETCH: `rd_req` drops in the next cycle; the memory must tolerate an abandoned request.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure

- **Shared package `mm_pkg`:**
  - state encoding localparams (IDLE=2'd0, FETCH=2'd1, SHOW=2'd2);
  - the default N, DATA_W and ADDR_W constants, shared with the multiplier and the result memory.
- **Sub-module `dwell_timer`:**
  - inputs: `clk`, `rst_n`, `clear`, `enable`;
  - output: `expire` pulse at count DWELL-1;
  - parameterised by DWELL.
- FSM, index register, restart flag and output registers live in the top module.

## Test plan

Run with N=2, DWELL=4, and memory contents {0x1111, 0x2222, 0x3333, 0x4444}, acking 1 cycle after each request.

1. **Normal walk and wrap.** Reset, then pulse `mm_done`. Required: `rd_addr` sequence 0,1,2,3,0; `disp_value` 0x1111..0x4444 then 0x1111; each element shown for 4 SHOW cycles; `busy`=1 throughout.
2. **Hold and skip.** Assert `btn_hold` for 10 cycles while showing 0x2222. Required: no advance. Then pulse `btn_next` while still held. Required: FETCH of addr 2 on the next cycle.
3. **Simultaneous advance.** Pulse `btn_next` in the same cycle as dwell expiry. Required: exactly one `idx` increment.
4. **Restart during FETCH.** Pulse `mm_done` while `rd_req` is high for addr 3. Required: the ack'd 0x4444 is not displayed, the next request is for addr 0, and `disp_value` becomes 0x1111.
5. **Slow memory.** Delay `rd_ack` by 20 cycles. Required: `rd_req`/`rd_addr` stable throughout and `disp_value` unchanged until the ack.
6. **Reset mid-SHOW.** Drive `rst_n`=0 for 1 cycle. Required: all outputs 0 and the state is IDLE; a later `btn_next` has no effect until the next `mm_done`.
